// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller port between an instruction
// fetch, a load and a store requester. One transaction is in flight at a
// time. Grants and all outputs are registered. Fetches can be cancelled by
// flush, and a starvation counter stops loads and stores from locking out
// fetches.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  // load requester
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_len,
  output logic [31:0] ld_data,
  output logic        ld_done,
  // store requester
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_len,
  output logic        st_done,
  // pipeline redirect
  input  logic        flush,
  // memory controller
  output logic        mc_r_req,
  output logic        mc_w_req,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_w_data,
  output logic [2:0]  mc_len,
  input  logic [31:0] mc_r_data,
  input  logic        mc_done
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_LD = 3'd2,
    BUSY_ST = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             mc_r_req_q, mc_r_req_d;
  logic             mc_w_req_q, mc_w_req_d;
  logic [31:0]      mc_addr_q, mc_addr_d;
  logic [31:0]      mc_w_data_q, mc_w_data_d;
  logic [2:0]       mc_len_q, mc_len_d;
  logic [31:0]      if_data_q, if_data_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic             if_done_q, if_done_d;
  logic             ld_done_q, ld_done_d;
  logic             st_done_q, st_done_d;

  // Only 1, 2 and 4 byte transfers exist on the controller; anything else
  // is widened to a full word.
  function automatic logic [2:0] wire_len(input logic [2:0] len);
    return (len == 3'd1 || len == 3'd2 || len == 3'd4) ? len : 3'd4;
  endfunction

  // A requester whose done is showing this cycle still has a stale req
  // up, so it is not eligible for a grant.
  logic if_pend, ld_pend, st_pend, if_ok, starved;
  assign if_pend = if_req & ~if_done_q;
  assign ld_pend = ld_req & ~ld_done_q;
  assign st_pend = st_req & ~st_done_q;
  assign if_ok   = if_pend & ~flush;
  assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Next-state, arbitration and output-register computation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mc_r_req_d   = mc_r_req_q;
    mc_w_req_d   = mc_w_req_q;
    mc_addr_d    = mc_addr_q;
    mc_w_data_d  = mc_w_data_q;
    mc_len_d     = mc_len_q;
    if_data_d    = if_data_q;
    ld_data_d    = ld_data_q;
    if_done_d    = 1'b0;
    ld_done_d    = 1'b0;
    st_done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!if_req) starve_cnt_d = '0;
        if (if_ok && (starved || (!st_pend && !ld_pend))) begin
          state_d      = BUSY_IF;
          mc_r_req_d   = 1'b1;
          mc_addr_d    = if_addr;
          mc_len_d     = 3'd4;
          mc_w_data_d  = '0;
          starve_cnt_d = '0;
        end else if (st_pend) begin
          state_d     = BUSY_ST;
          mc_w_req_d  = 1'b1;
          mc_addr_d   = st_addr;
          mc_len_d    = wire_len(st_len);
          mc_w_data_d = st_data;
          if (if_req && !starved) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (ld_pend) begin
          state_d     = BUSY_LD;
          mc_r_req_d  = 1'b1;
          mc_addr_d   = ld_addr;
          mc_len_d    = wire_len(ld_len);
          mc_w_data_d = '0;
          if (if_req && !starved) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end

      BUSY_IF: begin
        // A flush wins over a completion arriving in the same cycle.
        if (flush) begin
          if (mc_done) begin
            state_d    = IDLE;
            mc_r_req_d = 1'b0;
          end else begin
            state_d = DISCARD;
          end
        end else if (mc_done) begin
          state_d    = IDLE;
          mc_r_req_d = 1'b0;
          if_data_d  = mc_r_data;
          if_done_d  = 1'b1;
        end
      end

      BUSY_LD: begin
        if (mc_done) begin
          state_d    = IDLE;
          mc_r_req_d = 1'b0;
          ld_data_d  = mc_r_data;
          ld_done_d  = 1'b1;
        end
      end

      BUSY_ST: begin
        if (mc_done) begin
          state_d    = IDLE;
          mc_w_req_d = 1'b0;
          st_done_d  = 1'b1;
        end
      end

      DISCARD: begin
        // The controller cannot abort a read, so wait it out silently.
        if (mc_done) begin
          state_d    = IDLE;
          mc_r_req_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the reset branch clears every register asynchronously so the
    // controller request drops the moment rst falls, with no clock needed.
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mc_r_req_q   <= 1'b0;
      mc_w_req_q   <= 1'b0;
      mc_addr_q    <= '0;
      mc_w_data_q  <= '0;
      mc_len_q     <= '0;
      if_data_q    <= '0;
      ld_data_q    <= '0;
      if_done_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      st_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mc_r_req_q   <= mc_r_req_d;
      mc_w_req_q   <= mc_w_req_d;
      mc_addr_q    <= mc_addr_d;
      mc_w_data_q  <= mc_w_data_d;
      mc_len_q     <= mc_len_d;
      if_data_q    <= if_data_d;
      ld_data_q    <= ld_data_d;
      if_done_q    <= if_done_d;
      ld_done_q    <= ld_done_d;
      st_done_q    <= st_done_d;
    end
  end

  assign mc_r_req  = mc_r_req_q;
  assign mc_w_req  = mc_w_req_q;
  assign mc_addr   = mc_addr_q;
  assign mc_w_data = mc_w_data_q;
  assign mc_len    = mc_len_q;
  assign if_data   = if_data_q;
  assign ld_data   = ld_data_q;
  assign if_done   = if_done_q;
  assign ld_done   = ld_done_q;
  assign st_done   = st_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a
// transaction-level model of who owns the memory port.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int O_NONE = 0, O_IF = 1, O_LD = 2, O_ST = 3, O_DROP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ld_req, st_req, flush, mc_done;
  logic [31:0] if_addr, ld_addr, st_addr, st_data, mc_r_data;
  logic [2:0]  ld_len, st_len;
  logic [31:0] if_data, ld_data, mc_addr, mc_w_data;
  logic        if_done, ld_done, st_done, mc_r_req, mc_w_req;
  logic [2:0]  mc_len;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_data(ld_data), .ld_done(ld_done),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_len(st_len), .st_done(st_done),
    .flush(flush),
    .mc_r_req(mc_r_req), .mc_w_req(mc_w_req), .mc_addr(mc_addr), .mc_w_data(mc_w_data),
    .mc_len(mc_len), .mc_r_data(mc_r_data), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mc_r_req;
    logic        mc_w_req;
    logic [31:0] mc_addr;
    logic [31:0] mc_w_data;
    logic [2:0]  mc_len;
    logic [31:0] if_data;
    logic [31:0] ld_data;
    logic        if_done;
    logic        ld_done;
    logic        st_done;
  } outs_t;

  outs_t mdl;
  int    owner;
  int    starve;
  int    vectors = 0;
  int    miscompares = 0;
  bit    if_drop = 0, ld_drop = 0, st_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [2:0] len_of(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2 || l == 3'd4) ? l : 3'd4;
  endfunction

  task automatic model_reset();
    mdl    = '0;
    owner  = O_NONE;
    starve = 0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    outs_t n;
    n = mdl;
    n.if_done = 1'b0;
    n.ld_done = 1'b0;
    n.st_done = 1'b0;
    if (owner == O_NONE) begin
      bit ifp, ldp, stp, ifok;
      int win;
      ifp  = if_req && !mdl.if_done;
      ldp  = ld_req && !mdl.ld_done;
      stp  = st_req && !mdl.st_done;
      ifok = ifp && !flush;
      win  = O_NONE;
      if (ifok && starve == STARVE_LIMIT) win = O_IF;
      else if (stp)                       win = O_ST;
      else if (ldp)                       win = O_LD;
      else if (ifok)                      win = O_IF;
      case (win)
        O_IF: begin n.mc_r_req = 1; n.mc_addr = if_addr; n.mc_len = 3'd4; n.mc_w_data = 0; end
        O_LD: begin n.mc_r_req = 1; n.mc_addr = ld_addr; n.mc_len = len_of(ld_len); n.mc_w_data = 0; end
        O_ST: begin n.mc_w_req = 1; n.mc_addr = st_addr; n.mc_len = len_of(st_len); n.mc_w_data = st_data; end
        default: ;
      endcase
      if (!if_req || win == O_IF) starve = 0;
      else if (win == O_LD || win == O_ST) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
      owner = win;
    end else if (owner == O_IF && flush) begin
      if (mc_done) begin n.mc_r_req = 0; owner = O_NONE; end
      else owner = O_DROP;
    end else if (mc_done) begin
      if (owner == O_IF) begin n.if_data = mc_r_data; n.if_done = 1; end
      if (owner == O_LD) begin n.ld_data = mc_r_data; n.ld_done = 1; end
      if (owner == O_ST) n.st_done = 1;
      n.mc_r_req = 0;
      n.mc_w_req = 0;
      owner = O_NONE;
    end
    mdl = n;
  endtask

  task automatic compare_all();
    check("mc_r_req", mc_r_req, mdl.mc_r_req);
    check("mc_w_req", mc_w_req, mdl.mc_w_req);
    check("if_done",  if_done,  mdl.if_done);
    check("ld_done",  ld_done,  mdl.ld_done);
    check("st_done",  st_done,  mdl.st_done);
    check("if_data",  if_data,  mdl.if_data);
    check("ld_data",  ld_data,  mdl.ld_data);
    if (mdl.mc_r_req || mdl.mc_w_req) begin
      check("mc_addr",   mc_addr,   mdl.mc_addr);
      check("mc_len",    mc_len,    mdl.mc_len);
      check("mc_w_data", mc_w_data, mdl.mc_w_data);
    end
  endtask

  // One clock: predict, let the DUT take the edge, compare just after it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Hold mc_done low for n cycles, then complete with read data d.
  task automatic mc_finish(input int n, input logic [31:0] d);
    mc_done = 0;
    repeat (n) cycle();
    mc_done   = 1;
    mc_r_data = d;
    cycle();
    mc_done = 0;
  endtask

  // Random traffic: requesters and controller react to the model's view.
  task automatic rand_drive();
    mc_done   = (mdl.mc_r_req || mdl.mc_w_req) && ($urandom_range(0, 2) == 0);
    mc_r_data = $urandom;
    flush     = ($urandom_range(0, 9) == 0);
    if (if_drop) begin if_req = 0; if_drop = 0; end
    else if (if_req && (mdl.if_done || flush)) begin
      if (!flush && $urandom_range(0, 1) == 1) if_req = 0; else if_drop = 1;
    end else if (!if_req && $urandom_range(0, 3) == 0) begin
      if_req = 1; if_addr = $urandom;
    end
    if (ld_drop) begin ld_req = 0; ld_drop = 0; end
    else if (ld_req && mdl.ld_done) begin
      if ($urandom_range(0, 1) == 1) ld_req = 0; else ld_drop = 1;
    end else if (!ld_req && $urandom_range(0, 3) == 0) begin
      ld_req = 1; ld_addr = $urandom; ld_len = 3'($urandom_range(0, 7));
    end
    if (st_drop) begin st_req = 0; st_drop = 0; end
    else if (st_req && mdl.st_done) begin
      if ($urandom_range(0, 1) == 1) st_req = 0; else st_drop = 1;
    end else if (!st_req && $urandom_range(0, 3) == 0) begin
      st_req = 1; st_addr = $urandom; st_data = $urandom; st_len = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    rst = 0; if_req = 0; ld_req = 0; st_req = 0; flush = 0; mc_done = 0;
    if_addr = 0; ld_addr = 0; st_addr = 0; st_data = 0; mc_r_data = 0;
    ld_len = 0; st_len = 0;
    model_reset();
    #3;
    check("rst_mc_r_req", mc_r_req, 0);
    check("rst_mc_w_req", mc_w_req, 0);
    check("rst_mc_addr",  mc_addr,  0);
    check("rst_ld_data",  ld_data,  0);
    check("rst_dones",    {29'd0, if_done, ld_done, st_done}, 0);
    @(posedge clk);
    #1;
    rst = 1;

    // Single load, first edge after reset release grants it.
    ld_req = 1; ld_addr = 32'h100; ld_len = 3'd4;
    cycle();
    check("ld1_r_req", mc_r_req, 1);
    check("ld1_addr",  mc_addr,  32'h100);
    check("ld1_len",   mc_len,   3'd4);
    mc_finish(3, 32'hDEADBEEF);
    check("ld1_done",     ld_done,  1);
    check("ld1_data",     ld_data,  32'hDEADBEEF);
    check("ld1_req_drop", mc_r_req, 0);
    cycle();
    check("ld1_done_pulse", ld_done,  0);
    check("ld1_stale_req",  mc_r_req, 0);
    ld_req = 0;

    // Contention: store, then load, then fetch.
    if_req = 1; if_addr = 32'h400;
    ld_req = 1; ld_addr = 32'h300; ld_len = 3'd2;
    st_req = 1; st_addr = 32'h200; st_data = 32'h0A0B0C0D; st_len = 3'd4;
    cycle();
    check("ct_st_grant", mc_w_req, 1);
    check("ct_st_addr",  mc_addr,  32'h200);
    mc_finish(1, 32'h0);
    check("ct_st_done", st_done, 1);
    cycle();
    check("ct_ld_grant", mc_r_req, 1);
    check("ct_ld_addr",  mc_addr,  32'h300);
    st_req = 0;
    mc_finish(2, 32'h11112222);
    check("ct_ld_data", ld_data, 32'h11112222);
    cycle();
    check("ct_if_addr", mc_addr, 32'h400);
    check("ct_if_len",  mc_len,  3'd4);
    ld_req = 0;
    mc_finish(0, 32'hCAFEF00D);
    check("ct_if_data", if_data, 32'hCAFEF00D);
    if_req = 0;
    cycle();

    // Starvation: fetch wins the 5th arbitration, twice in a row.
    if_req = 1; if_addr = 32'h500;
    ld_req = 1; ld_addr = 32'h600; ld_len = 3'd4;
    st_req = 1; st_addr = 32'h700; st_data = 32'h77; st_len = 3'd1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        cycle();
        check("sv_ldst_grant", {30'd0, mc_w_req, mc_r_req}, (i % 2 == 0) ? 32'd2 : 32'd1);
        mc_finish(1, 32'h1000 + 32'(i));
      end
      cycle();
      check("sv_if_grant", mc_r_req, 1);
      check("sv_if_addr",  mc_addr,  32'h500);
      mc_finish(0, 32'hA5A50000 + 32'(r));
      check("sv_if_done", if_done, 1);
    end
    if_req = 0; ld_req = 0; st_req = 0;
    cycle();

    // Flush mid-fetch: read runs to completion silently, then the load.
    if_req = 1; if_addr = 32'h800;
    cycle();
    check("fl_if_grant", mc_r_req, 1);
    flush = 1; ld_req = 1; ld_addr = 32'h900; ld_len = 3'd2;
    cycle();
    check("fl_hold", mc_r_req, 1);
    flush = 0; if_req = 0;
    mc_finish(2, 32'h12345678);
    check("fl_req_drop", mc_r_req, 0);
    check("fl_no_done",  if_done,  0);
    check("fl_if_data",  if_data,  32'hA5A50001);
    cycle();
    check("fl_ld_grant", mc_r_req, 1);
    check("fl_ld_addr",  mc_addr,  32'h900);
    check("fl_ld_len",   mc_len,   3'd2);
    mc_finish(0, 32'h9);
    ld_req = 0;
    cycle();

    // Flush together with completion resolves as a flush.
    if_req = 1; if_addr = 32'hA00;
    cycle();
    flush = 1; mc_done = 1; mc_r_data = 32'hFFFFFFFF;
    cycle();
    check("fd_req_drop", mc_r_req, 0);
    check("fd_no_done",  if_done,  0);
    flush = 0; mc_done = 0; if_req = 0;
    cycle();
    check("fd_if_data", if_data, 32'hA5A50001);

    // Length mapping on stores.
    st_req = 1; st_addr = 32'hB00; st_data = 32'h0BADF00D; st_len = 3'd3;
    cycle();
    check("len3_len",   mc_len,    3'd4);
    check("len3_wdata", mc_w_data, 32'h0BADF00D);
    mc_finish(0, 32'h0);
    st_req = 0;
    cycle();
    st_req = 1; st_data = 32'h55AA55AA; st_len = 3'd1;
    cycle();
    check("len1_len",   mc_len,    3'd1);
    check("len1_wdata", mc_w_data, 32'h55AA55AA);
    mc_finish(0, 32'h0);
    st_req = 0;
    cycle();

    // Reset in the middle of a store.
    st_req = 1; st_addr = 32'hC00; st_len = 3'd2;
    cycle();
    check("rs_w_req", mc_w_req, 1);
    #2;
    rst = 0;
    #1;
    check("rs_async_w_req", mc_w_req, 0);
    check("rs_async_addr",  mc_addr,  0);
    check("rs_async_done",  st_done,  0);
    st_req = 0;
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    cycle();
    check("rs_idle_w_req", mc_w_req, 0);
    check("rs_no_done",    st_done,  0);

    // Randomized traffic.
    repeat (3000) begin
      rand_drive();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
